// File: rtl/axis_framer_pkg.sv
// Shared types and helpers for the AXI-Stream sample framer.
//   state_e     : packing FSM states (low half, high half, checksum beat)
//   PACK_RATIO  : samples packed per output beat (OUT_WIDTH = PACK_RATIO * IN_WIDTH)
//   cnt_width() : counter width able to hold n-1, never narrower than one bit
package axis_framer_pkg;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_SUM = 2'd2
  } state_e;

  localparam int unsigned PACK_RATIO = 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_sample_framer.sv
// Packs 16-bit samples pairwise into 32-bit beats, groups FRAME_BEATS beats
// into a frame closed by a checksum beat (m_axis_last), and pad-flushes a
// half-filled beat after TIMEOUT_CYCLES idle cycles.
// Ports:
//   aclk, rstn                           clock, async active-low reset
//   s_axis_data/vld/rdy                  sample input stream
//   m_axis_data/vld/last/rdy             beat output stream (single register stage)
//   frame_cnt                            completed frames, wrapping
//   pad_flush                            one-cycle pulse when a padded beat is loaded
module axis_sample_framer
  import axis_framer_pkg::*;
#(
  parameter int unsigned IN_WIDTH        = 16,
  parameter int unsigned OUT_WIDTH       = 32,
  parameter int unsigned FRAME_BEATS     = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 256,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                       aclk,
  input  logic                       rstn,
  input  logic [IN_WIDTH-1:0]        s_axis_data,
  input  logic                       s_axis_vld,
  output logic                       s_axis_rdy,
  output logic [OUT_WIDTH-1:0]       m_axis_data,
  output logic                       m_axis_vld,
  output logic                       m_axis_last,
  input  logic                       m_axis_rdy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       pad_flush
);

  localparam int unsigned BcntW = cnt_width(FRAME_BEATS);
  localparam int unsigned TcntW = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned HiW   = OUT_WIDTH - (OUT_WIDTH / PACK_RATIO);
  localparam logic [BcntW-1:0] LastBeat = BcntW'(FRAME_BEATS - 1);
  localparam logic [TcntW-1:0] TcntMax  = TcntW'(TIMEOUT_CYCLES - 1);

  state_e                     state_q, state_d;
  logic [IN_WIDTH-1:0]        lo_q, lo_d;
  logic [BcntW-1:0]           bcnt_q, bcnt_d;
  logic [TcntW-1:0]           tcnt_q, tcnt_d;
  logic [OUT_WIDTH-1:0]       csum_q, csum_d;
  logic [OUT_WIDTH-1:0]       m_data_q, m_data_d;
  logic                       m_vld_q, m_vld_d;
  logic                       m_last_q, m_last_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       pad_q, pad_d;

  logic                       out_free;
  logic                       in_hs;
  logic                       load_beat;
  logic [OUT_WIDTH-1:0]       beat;

  // Output register can accept a new beat this cycle.
  assign out_free   = ~m_vld_q | m_axis_rdy;
  // S_LO only stores the sample internally, so it never waits on the output.
  assign s_axis_rdy = rstn & (state_q != S_SUM) & ((state_q == S_LO) | out_free);
  assign in_hs      = s_axis_vld & s_axis_rdy;

  // Next-state logic for the FSM, checksum, counters and output register.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;
    csum_d      = csum_q;
    m_data_d    = m_data_q;
    m_vld_d     = m_vld_q;
    m_last_d    = m_last_q;
    frame_cnt_d = frame_cnt_q;
    pad_d       = 1'b0;
    load_beat   = 1'b0;
    beat        = '0;

    if (out_free) begin
      m_vld_d = 1'b0;
    end

    case (state_q)
      S_LO: begin
        tcnt_d = '0;
        if (in_hs) begin
          lo_d    = s_axis_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        // A real sample wins over the timeout in the same cycle.
        if (in_hs) begin
          load_beat = 1'b1;
          beat      = {s_axis_data, lo_q};
        end else if (tcnt_q == TcntMax) begin
          if (out_free) begin
            load_beat = 1'b1;
            beat      = {HiW'(0), lo_q};
            pad_d     = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + TcntW'(1);
        end
      end
      S_SUM: begin
        tcnt_d = '0;
        if (out_free) begin
          m_data_d = csum_q;
          m_vld_d  = 1'b1;
          m_last_d = 1'b1;
          csum_d   = '0;
          bcnt_d   = '0;
          state_d  = S_LO;
        end
      end
      default: state_d = S_LO;
    endcase

    // Data beat load shared by the paired and padded paths.
    if (load_beat) begin
      m_data_d = beat;
      m_vld_d  = 1'b1;
      m_last_d = 1'b0;
      csum_d   = csum_q + beat;
      bcnt_d   = bcnt_q + BcntW'(1);
      tcnt_d   = '0;
      state_d  = (bcnt_q == LastBeat) ? S_SUM : S_LO;
    end

    if (m_vld_q & m_axis_rdy & m_last_q) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_LO;
      lo_q        <= '0;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
      csum_q      <= '0;
      m_data_q    <= '0;
      m_vld_q     <= 1'b0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= '0;
      pad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
      csum_q      <= csum_d;
      m_data_q    <= m_data_d;
      m_vld_q     <= m_vld_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
      pad_q       <= pad_d;
    end
  end

  assign m_axis_data = m_data_q;
  assign m_axis_vld  = m_vld_q;
  assign m_axis_last = m_last_q;
  assign frame_cnt   = frame_cnt_q;
  assign pad_flush   = pad_q;

endmodule
